// File: rtl/pkt_arb_pkg.sv
// rtl/pkt_arb_pkg.sv - shared types and header helpers for the packet source arbiter
package pkt_arb_pkg;

  typedef enum logic [1:0] {IDLE, HDR, PAY} arb_state_t;

  localparam int LEN_LSB   = 0;
  localparam int DEF_LEN_W = 16;
  localparam int HDR_W     = 32;

  // Returns the length field of a header word, masked to len_w bits.
  function automatic logic [HDR_W-1:0] hdr_len(input logic [HDR_W-1:0] hdr,
                                               input int len_w);
    logic [HDR_W-1:0] mask;
    mask = (len_w >= HDR_W) ? '1 : ((HDR_W'(1) << len_w) - HDR_W'(1));
    return (hdr >> LEN_LSB) & mask;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick of the first requester at or after rr_ptr
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_any
);

  assign gnt_any = |req;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    int cand;
    cand    = 0;
    gnt_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = int'(rr_ptr) + k;
      if (cand >= N) cand = cand - N;
      if (req[IW'(cand)]) gnt_idx = IW'(cand);
    end
  end

endmodule

// File: rtl/pkt_src_arbiter.sv
// rtl/pkt_src_arbiter.sv - packet-granular round-robin arbiter feeding the parser
module pkt_src_arbiter
  import pkt_arb_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_W      = DEF_LEN_W,
  localparam int IDX_W     = $clog2(NUM_SRC)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]  src_data,
  input  logic [NUM_SRC-1:0]                  src_valid,
  output logic [NUM_SRC-1:0]                  src_ready,
  output logic [DATA_WIDTH-1:0]               data_out,
  output logic                                valid_out,
  input  logic                                ready_in,
  output logic [IDX_W-1:0]                    grant_id,
  output logic                                busy,
  output logic                                pkt_done
);

  arb_state_t        r_state;
  logic [IDX_W-1:0]  r_rr_ptr;
  logic [IDX_W-1:0]  r_grant;
  logic [LEN_W-1:0]  r_remaining;
  logic              r_busy;
  logic              r_pkt_done;

  logic [IDX_W-1:0]  w_gnt_idx;
  logic              w_gnt_any;
  logic              w_hs;
  logic [LEN_W-1:0]  w_len;
  logic [IDX_W-1:0]  w_next_ptr;

  rr_arbiter #(.N(NUM_SRC)) u_rr (
    .req     (src_valid),
    .rr_ptr  (r_rr_ptr),
    .gnt_idx (w_gnt_idx),
    .gnt_any (w_gnt_any)
  );

  // Data path is pure pass-through of the granted source; r_busy gates it off in IDLE.
  assign data_out  = src_data[r_grant];
  assign valid_out = r_busy & src_valid[r_grant];
  assign w_hs      = valid_out & ready_in;
  assign w_len     = LEN_W'(hdr_len(HDR_W'(data_out), LEN_W));
  assign w_next_ptr = (r_grant == IDX_W'(NUM_SRC - 1)) ? '0 : r_grant + IDX_W'(1);

  always_comb begin
    src_ready          = '0;
    src_ready[r_grant] = r_busy & ready_in;
  end

  assign grant_id = r_grant;
  assign busy     = r_busy;
  assign pkt_done = r_pkt_done;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_grant     <= '0;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_pkt_done  <= 1'b0;
    end else begin
      r_pkt_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_gnt_any) begin
            r_grant <= w_gnt_idx;
            r_busy  <= 1'b1;
            r_state <= HDR;
          end
        end
        HDR: begin
          if (w_hs) begin
            if (w_len == '0) begin
              r_pkt_done <= 1'b1;
              r_rr_ptr   <= w_next_ptr;
              r_busy     <= 1'b0;
              r_state    <= IDLE;
            end else begin
              r_remaining <= w_len;
              r_state     <= PAY;
            end
          end
        end
        PAY: begin
          if (w_hs) begin
            r_remaining <= r_remaining - LEN_W'(1);
            if (r_remaining == LEN_W'(1)) begin
              r_pkt_done <= 1'b1;
              r_rr_ptr   <= w_next_ptr;
              r_busy     <= 1'b0;
              r_state    <= IDLE;
            end
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/pkt_src_arbiter.md
Name: pkt_src_arbiter

Overview:
- Packet-level round-robin arbiter that lets NUM_SRC packet sources share the single parser + output FIFO pipeline.
- Sits between the sources and the parser input (data_in / parser_valid_in / parser_ready_in).
- Grants one source for a whole packet (header + payload), so packets are never interleaved.
- Packet length comes from the header word.

Parameters:
- NUM_SRC, 4, number of requesting packet sources (2..16).
- DATA_WIDTH, 32, word width; matches the parser.
- LEN_W, 16, width of the payload-length field in header bits [LEN_W-1:0].

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- src_data  in  NUM_SRC x DATA_WIDTH  per-source word.
- src_valid  in  NUM_SRC  per-source word valid.
- src_ready  out  NUM_SRC  per-source accept.
- data_out  out  DATA_WIDTH  word to parser data_in.
- valid_out  out  1  to parser_valid_in.
- ready_in  in  1  from parser_ready_in.
- grant_id  out  $clog2(NUM_SRC)  currently granted source.
- busy  out  1  high while a packet is in flight (state HDR or PAY).
- pkt_done  out  1  one-cycle pulse on the final word handshake of a packet.

Behaviour:
- Handshake: a transfer occurs on a cycle where valid_out && ready_in.
- Source rule: once src_valid[i] rises, it holds until the handshake. The arbiter does not support source withdrawal.
- Reset (rst==0 at a clock edge) sets:
  - state=IDLE, rr_ptr=0, grant_id=0, remaining=0
  - busy=0, pkt_done=0, valid_out=0, src_ready=0
  - Reset mid-packet abandons the packet; the source is not notified.
- IDLE state:
  - valid_out=0, all src_ready=0.
  - If any src_valid is high, pick the first requester at or after rr_ptr (wrapping modulo NUM_SRC), register grant_id, and go to HDR next cycle.
  - This costs exactly one bubble cycle per packet.
- HDR state:
  - data_out=src_data[grant_id], valid_out=src_valid[grant_id], src_ready[grant_id]=ready_in. All other src_ready=0.
  - All three paths are combinational pass-through; the block adds zero latency on data.
  - On handshake, capture len=data_out[LEN_W-1:0].
  - If len==0: pulse pkt_done, set rr_ptr=grant_id+1 (mod NUM_SRC), go to IDLE.
  - Otherwise: remaining=len, go to PAY.
- PAY state:
  - Same pass-through as HDR.
  - On each handshake, remaining decrements.
  - On the handshake where remaining==1: pulse pkt_done, set rr_ptr=grant_id+1 (mod NUM_SRC), go to IDLE.
- Stalls:
  - ready_in low freezes state and remaining.
  - Granted source dropping valid mid-packet holds the grant indefinitely (no timeout). Other requesters wait.
- Width and wrap rules:
  - remaining is LEN_W bits.
  - Maximum len is 2^LEN_W-1; this is handled without overflow.
  - rr_ptr wrap from NUM_SRC-1 goes to 0. NUM_SRC need not be a power of 2.
- Fairness: with all sources always requesting, grants rotate 0,1,2,...,NUM_SRC-1,0.
- Simultaneous events: a new request arriving during a packet is ignored until IDLE. The arbitration sample is taken in the IDLE cycle only.
- Output latches: grant_id and busy are registered; pkt_done is registered and high for the cycle after the final handshake.

Decomposition:
- Package pkt_arb_pkg holds:
  - state enum arb_state_t {IDLE, HDR, PAY}
  - localparams LEN_LSB=0 and the default LEN_W
  - function hdr_len() extracting the length from a header word
- Sub-module rr_arbiter (parameter N): purely combinational.
  - Inputs: request vector, rr_ptr.
  - Outputs: gnt_idx, gnt_any.
  - Instantiated once.
- The top-level FSM, counter and mux live in pkt_src_arbiter.

Test Plan:
- Reset check: rst low for 2 cycles during a PAY transfer, then high → valid_out=0, busy=0, grant_id=0; the next packet from src 2 is granted cleanly.
- Single source: src1 sends header len=3 plus words A,B,C with ready_in=1 → data_out sequence is hdr,A,B,C on consecutive cycles. pkt_done pulses after C; one IDLE bubble follows.
- Round robin: all 4 sources continuously send len=1 packets → grant_id order is 0,1,2,3,0 and no packet is interleaved.
- Zero-length and max-length packets:
  - header len=0 → pkt_done after the header alone.
  - len=65535 → exactly 65536 words transferred, then IDLE.
- Backpressure: ready_in toggling 1,0,0,1 mid-payload → no word lost or duplicated; remaining frozen while ready_in=0; src_ready of non-granted sources stays 0.
- Integrated with parser+FIFO: FIFO filled to full → parser_ready_in low propagates to src_ready[grant]=0; after fifo_rd_en drains, transfer resumes with intact word order.
